// File: rtl/frame_reader_pkg.sv
// rtl/frame_reader_pkg.sv - shared state encoding, header constants and helpers for frame_reader
package frame_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_HDR,
    ST_DATA,
    ST_DRAIN
  } state_t;

  typedef logic [3:0][7:0] cnt_arr_t;

  localparam logic [7:0] HDR_MARK  = 8'hA5;
  localparam int         HDR_WORDS = 4;

  function automatic logic [31:0] hdr_word(input logic [1:0] k, input logic [7:0] c);
    return {HDR_MARK, 6'd0, k, 8'h00, c};
  endfunction

  // Lowest channel >= from with a non-zero count; bit 2 set means none left.
  function automatic logic [2:0] next_chan(input cnt_arr_t cnts, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b100;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= from && cnts[i] != 8'd0) r = {1'b0, 2'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_reader_rd_skid_fifo.sv
// rtl/frame_reader_rd_skid_fifo.sv - synchronous first-word-fall-through skid FIFO with level output
module rd_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             wr_ok, rd_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign wr_ok   = wr_en & ~full;
  assign rd_ok   = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (rd_ok) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    level_d = level_q + LW'(wr_ok) - LW'(rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - reads per-channel buffer words and streams them as a framed packet
module frame_reader
  import frame_reader_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_frame_ready,
  input  logic [15:0] i_out_size,
  input  logic [7:0]  i_data_count,
  output logic [1:0]  o_rd_vchn,
  output logic [7:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_tdata,
  output logic        o_tvalid,
  input  logic        i_tready,
  output logic        o_tsof,
  output logic        o_teof,
  output logic        o_busy,
  output logic [7:0]  o_drop_cnt,
  output logic        o_size_err
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic                  sync1_q, sync2_q, sync3_q;
  state_t                state_q, state_d;
  logic [1:0]            vchn_q, vchn_d, hdr_k_q, hdr_k_d;
  logic [7:0]            addr_q, addr_d, drop_q, drop_d, inflight;
  logic                  phase_q, phase_d, busy_q, busy_d, size_err_q, size_err_d;
  cnt_arr_t              cnt_q, cnt_d;
  logic [15:0]           out_size_q, out_size_d, words_q, words_d;
  logic [RD_LATENCY-1:0] pipe_vld_q, pipe_vld_d, pipe_eof_q, pipe_eof_d;

  logic        frame_evt, accept, issue, last_rd, hdr_push, hdr_sof, hdr_eof;
  logic        fifo_wr, fifo_full, fifo_empty;
  logic [33:0] fifo_wdata, fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic [2:0]  nxt;
  logic [31:0] hdr_data;

  assign frame_evt  = sync2_q & ~sync3_q;
  assign accept     = o_tvalid & i_tready;
  assign o_tvalid   = ~fifo_empty;
  assign o_tdata    = fifo_rdata[31:0];
  assign o_teof     = fifo_rdata[32] & ~fifo_empty;
  assign o_tsof     = fifo_rdata[33] & ~fifo_empty;
  assign o_rd_vchn  = vchn_q;
  assign o_rd_addr  = addr_q;
  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;
  assign o_size_err = size_err_q;

  assign fifo_wr    = hdr_push | pipe_vld_q[RD_LATENCY-1];
  assign fifo_wdata = hdr_push ? {hdr_sof, hdr_eof, hdr_data}
                               : {1'b0, pipe_eof_q[RD_LATENCY-1], i_rd_data};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + 8'(pipe_vld_q[i]);
  end

  always_comb begin
    state_d    = state_q;
    vchn_d     = vchn_q;
    addr_d     = addr_q;
    phase_d    = phase_q;
    hdr_k_d    = hdr_k_q;
    cnt_d      = cnt_q;
    out_size_d = out_size_q;
    words_d    = words_q;
    drop_d     = drop_q;
    size_err_d = size_err_q;
    issue      = 1'b0;
    last_rd    = 1'b0;
    hdr_push   = 1'b0;
    nxt        = 3'b100;
    hdr_data   = hdr_word(hdr_k_q, cnt_q[hdr_k_q]);
    hdr_sof    = (hdr_k_q == 2'd0);
    hdr_eof    = (hdr_k_q == 2'(HDR_WORDS - 1)) && (cnt_q == '0);

    if (frame_evt && (state_q != ST_IDLE || !i_enable) && drop_q != 8'hFF) drop_d = drop_q + 8'd1;

    if (accept) begin
      words_d = words_q + 16'd1;
      if (o_teof && (words_q + 16'd1) != out_size_q) size_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (frame_evt && i_enable) begin
          state_d    = ST_CAPT;
          out_size_d = i_out_size;
          vchn_d     = 2'd0;
          addr_d     = 8'd0;
          phase_d    = 1'b0;
          hdr_k_d    = 2'd0;
          words_d    = 16'd0;
        end
      end
      ST_CAPT: begin
        // First cycle lets the count mux settle on the new channel, second samples it.
        phase_d = ~phase_q;
        if (phase_q) begin
          cnt_d[vchn_q] = i_data_count;
          if (vchn_q == 2'd3) state_d = ST_HDR;
          else vchn_d = vchn_q + 2'd1;
        end
      end
      ST_HDR: begin
        if (!fifo_full) begin
          hdr_push = 1'b1;
          hdr_k_d  = hdr_k_q + 2'd1;
          if (hdr_k_q == 2'(HDR_WORDS - 1)) begin
            nxt = next_chan(cnt_q, 3'd0);
            if (nxt[2]) state_d = ST_DRAIN;
            else begin
              state_d = ST_DATA;
              vchn_d  = nxt[1:0];
              addr_d  = 8'd0;
            end
          end
        end
      end
      ST_DATA: begin
        // The address register always holds the next read; it issues once credit allows.
        if (int'(fifo_level) + int'(inflight) < FIFO_DEPTH) begin
          issue = 1'b1;
          if ({1'b0, addr_q} + 9'd1 < {1'b0, cnt_q[vchn_q]}) addr_d = addr_q + 8'd1;
          else begin
            nxt = next_chan(cnt_q, {1'b0, vchn_q} + 3'd1);
            if (nxt[2]) begin
              last_rd = 1'b1;
              state_d = ST_DRAIN;
            end else begin
              vchn_d = nxt[1:0];
              addr_d = 8'd0;
            end
          end
        end
      end
      ST_DRAIN: begin
        if ((accept && o_teof) || (fifo_empty && inflight == 8'd0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d        = (state_d != ST_IDLE);
    pipe_vld_d    = pipe_vld_q;
    pipe_eof_d    = pipe_eof_q;
    pipe_vld_d[0] = issue;
    pipe_eof_d[0] = last_rd;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_eof_d[i] = pipe_eof_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      state_q    <= ST_IDLE;
      vchn_q     <= '0;
      addr_q     <= '0;
      phase_q    <= 1'b0;
      hdr_k_q    <= '0;
      cnt_q      <= '0;
      out_size_q <= '0;
      words_q    <= '0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
      size_err_q <= 1'b0;
      pipe_vld_q <= '0;
      pipe_eof_q <= '0;
    end else begin
      sync1_q    <= i_frame_ready;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      state_q    <= state_d;
      vchn_q     <= vchn_d;
      addr_q     <= addr_d;
      phase_q    <= phase_d;
      hdr_k_q    <= hdr_k_d;
      cnt_q      <= cnt_d;
      out_size_q <= out_size_d;
      words_q    <= words_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      size_err_q <= size_err_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_eof_q <= pipe_eof_d;
    end
  end

  rd_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (34),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (accept),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_frame_reader.sv
// tb/tb_frame_reader.sv - scoreboard bench for frame_reader
module tb_frame_reader;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_frame_ready = 1'b0;
  logic [15:0] i_out_size = '0;
  logic [7:0]  i_data_count;
  logic [1:0]  o_rd_vchn;
  logic [7:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic [31:0] o_tdata;
  logic        o_tvalid, o_tsof, o_teof, o_busy, o_size_err;
  logic        i_tready = 1'b1;
  logic [7:0]  o_drop_cnt;

  int          cnt_tb [4];
  logic [31:0] rd_pipe [RD_LATENCY];
  logic [33:0] exp_q [$];
  logic [33:0] exp_w, prev_word;
  int          checks_cnt = 0;
  int          fail_cnt = 0;
  int          acc_cnt = 0;
  int          exp_words = 0;
  bit          toggle_mode = 1'b0;
  bit          hold_prev = 1'b0;

  frame_reader #(
    .RD_LATENCY (RD_LATENCY),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (i_enable),
    .i_frame_ready (i_frame_ready),
    .i_out_size    (i_out_size),
    .i_data_count  (i_data_count),
    .o_rd_vchn     (o_rd_vchn),
    .o_rd_addr     (o_rd_addr),
    .i_rd_data     (i_rd_data),
    .o_tdata       (o_tdata),
    .o_tvalid      (o_tvalid),
    .i_tready      (i_tready),
    .o_tsof        (o_tsof),
    .o_teof        (o_teof),
    .o_busy        (o_busy),
    .o_drop_cnt    (o_drop_cnt),
    .o_size_err    (o_size_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [1:0] v, input logic [7:0] a);
    return {4'hD, 2'b00, v, 8'h00, a, ~a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Buffer model: registered read path of RD_LATENCY stages.
  assign i_data_count = 8'(cnt_tb[o_rd_vchn]);
  assign i_rd_data    = rd_pipe[RD_LATENCY-1];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_f(o_rd_vchn, o_rd_addr);
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      i_tready = toggle_mode ? ~i_tready : 1'b1;
      if (hold_prev) begin
        chk("hold_valid", 64'(o_tvalid), 64'd1);
        chk("hold_word", 64'({o_tsof, o_teof, o_tdata}), 64'(prev_word));
      end
      if (o_tvalid && i_tready) begin
        chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          chk("word", 64'({o_tsof, o_teof, o_tdata}), 64'(exp_w));
        end
        acc_cnt++;
      end
      hold_prev = o_tvalid && !i_tready;
      prev_word = {o_tsof, o_teof, o_tdata};
    end
  end

  task automatic start_frame(input int c0, input int c1, input int c2, input int c3, input int size);
    int total;
    cnt_tb[0] = c0; cnt_tb[1] = c1; cnt_tb[2] = c2; cnt_tb[3] = c3;
    total = c0 + c1 + c2 + c3;
    i_out_size = 16'(size);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({(k == 0), (k == 3 && total == 0), 8'hA5, 6'd0, 2'(k), 8'h00, 8'(cnt_tb[k])});
    for (int v = 0; v < 4; v++)
      for (int a = 0; a < cnt_tb[v]; a++)
        exp_q.push_back({1'b0, (v == 3 || cnt_tb[3] == 0 && (v == 2 || cnt_tb[2] == 0 && (v == 1 || cnt_tb[1] == 0)))
                               && a == cnt_tb[v] - 1, mem_f(2'(v), 8'(a))});
    exp_words = 4 + total;
    acc_cnt = 0;
    @(negedge clk);
    i_frame_ready = 1'b1;
    repeat (6) @(negedge clk);
    i_frame_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int n = 0; n < budget && (exp_q.size() != 0 || o_busy); n++) @(negedge clk);
    chk({tag, "_done"}, {31'd0, o_busy, 32'(exp_q.size())}, 64'd0);
    chk({tag, "_count"}, 64'(acc_cnt), 64'(exp_words));
  endtask

  initial begin
    cnt_tb = '{0, 0, 0, 0};
    #1;
    chk("rst_tvalid", 64'(o_tvalid), 64'd0);
    chk("rst_tsof", 64'(o_tsof), 64'd0);
    chk("rst_teof", 64'(o_teof), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_drop", 64'(o_drop_cnt), 64'd0);
    chk("rst_size_err", 64'(o_size_err), 64'd0);
    chk("rst_rd", 64'({o_rd_vchn, o_rd_addr}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    i_enable = 1'b1;
    repeat (2) @(negedge clk);

    start_frame(3, 0, 2, 1, 10);
    wait_done("f_basic", 500);
    chk("f_basic_size_err", 64'(o_size_err), 64'd0);

    start_frame(0, 0, 0, 0, 4);
    wait_done("f_empty", 500);
    chk("f_empty_size_err", 64'(o_size_err), 64'd0);

    toggle_mode = 1'b1;
    start_frame(255, 255, 255, 255, 1024);
    wait_done("f_full", 6000);
    chk("f_full_size_err", 64'(o_size_err), 64'd0);
    toggle_mode = 1'b0;

    start_frame(20, 20, 20, 20, 84);
    repeat (3) @(negedge clk);
    chk("busy_at_2nd", 64'(o_busy), 64'd1);
    i_frame_ready = 1'b1;
    repeat (6) @(negedge clk);
    i_frame_ready = 1'b0;
    wait_done("f_drop", 1000);
    chk("drop_busy", 64'(o_drop_cnt), 64'd1);

    i_enable = 1'b0;
    i_frame_ready = 1'b1;
    repeat (6) @(negedge clk);
    i_frame_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("disabled_busy", 64'(o_busy), 64'd0);
    chk("drop_disabled", 64'(o_drop_cnt), 64'd2);
    i_enable = 1'b1;

    start_frame(1, 2, 3, 0, 12);
    wait_done("f_sizeerr", 500);
    chk("size_err_set", 64'(o_size_err), 64'd1);

    start_frame(50, 50, 50, 50, 204);
    for (int n = 0; n < 500 && acc_cnt < 20; n++) @(negedge clk);
    chk("pre_rst_progress", 64'(acc_cnt >= 20), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(o_tvalid), 64'd0);
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_size_err", 64'(o_size_err), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_frame(3, 0, 2, 1, 10);
    wait_done("f_after_rst", 500);
    chk("after_rst_size_err", 64'(o_size_err), 64'd0);
    chk("after_rst_drop", 64'(o_drop_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
FRAME_READER -- requirements
Module: frame_reader

Interface
REQ-001 Parameter RD_LATENCY, default 2: cycles from o_rd_addr/o_rd_vchn change to valid i_rd_data.
REQ-002 Parameter FIFO_DEPTH, default 4: output skid FIFO depth in words; SHALL be >= RD_LATENCY+2.
REQ-003 clk  in  1  system clock; channel buffer read port runs on it.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 i_enable  in  1  permits starting a new frame.
REQ-006 i_frame_ready  in  1  frame-complete level from the capture clock domain (asynchronous).
REQ-007 i_out_size  in  16  total frame words (4 header + data), stable while i_frame_ready high.
REQ-008 i_data_count  in  8  word count of the virtual channel selected by o_rd_vchn.
REQ-009 o_rd_vchn  out  2  virtual channel select for the buffer read port and count mux.
REQ-010 o_rd_addr  out  8  word address within the selected channel.
REQ-011 i_rd_data  in  32  buffer read data, RD_LATENCY cycles after the address.
REQ-012 o_tdata  out  32  stream data.
REQ-013 o_tvalid / i_tready  out/in  1/1  stream handshake.
REQ-014 o_tsof / o_teof  out  1/1  first / last word of frame, qualified by o_tvalid.
REQ-015 o_busy  out  1  high from frame start until the last word is accepted.
REQ-016 o_drop_cnt  out  8  saturating count of frames missed while busy or disabled.
REQ-017 o_size_err  out  1  sticky: emitted word count differed from latched i_out_size.

Function
REQ-018 i_frame_ready SHALL pass a 2-flop synchronizer; a rising edge of the synchronized level is a frame event.
REQ-019 States: IDLE, CAPT, HDR, DATA, DRAIN.
REQ-020 IDLE: frame event with i_enable=1 -> CAPT, latch i_out_size, o_busy=1; with i_enable=0 -> stay, o_drop_cnt+1.
REQ-021 Frame event in any non-IDLE state: o_drop_cnt+1 (saturate at 255); current frame continues unaffected.
REQ-022 CAPT: step o_rd_vchn 0..3, 2 cycles per channel, sample i_data_count on the second cycle into cnt[k]; 8 cycles -> HDR.
REQ-023 HDR: push header word k = {8'hA5, 6'd0, k[1:0], 8'h00, cnt[k]} for k=0..3 into the FIFO, one per cycle when FIFO not full; after k=3 -> DATA.
REQ-024 DATA: issue reads for vchn 0..3, addr 0..cnt[k]-1; channels with cnt=0 skipped; at most one read issued per cycle.
REQ-025 A read SHALL issue only when FIFO occupancy + in-flight reads < FIFO_DEPTH; data returned RD_LATENCY cycles later is pushed unconditionally.
REQ-026 After the last read is issued -> DRAIN; DRAIN -> IDLE when FIFO empty and no reads in flight; o_busy drops the same cycle.
REQ-027 Word order on the stream: 4 headers, then vchn 0 words ascending, then vchn 1, 2, 3.
REQ-028 o_tdata/o_tsof/o_teof SHALL hold stable while o_tvalid=1 and i_tready=0.
REQ-029 o_tsof on header word 0; o_teof on the last data word, or on header word 3 if all cnt=0.
REQ-030 At o_teof acceptance, if emitted words != latched out_size, o_size_err<=1 (cleared only by reset).
REQ-031 Throughput: with i_tready=1 continuously, one word per cycle after FIFO fill; no bubbles inside DATA.
REQ-032 Word counter width 16 bits; maximum frame is 4 + 4*255 = 1024 words.

Reset
REQ-033 Asynchronous reset: state IDLE, o_tvalid=0, o_tsof=0, o_teof=0, o_busy=0, o_drop_cnt=0, o_size_err=0, o_rd_vchn=0, o_rd_addr=0, FIFO empty, in-flight counter 0, synchronizer flops 0.
REQ-034 Reset mid-frame SHALL discard the frame; the first frame event after reset release starts a fresh frame.

Structure
REQ-035 Shared package holds the state encoding, header marker 8'hA5 and header word count 4.
REQ-036 One sub-module: rd_skid_fifo (synchronous, FIFO_DEPTH x 32 plus sof/eof bits, full/empty/level outputs).

Verification
REQ-037 Counts 3,0,2,1, out_size 10, tready=1 -> 10 words: A5000003, A5010000, A5020002, A5030001, v0 a0..2, v2 a0..1, v3 a0; tsof word 1, teof word 10, size_err=0.
REQ-038 Counts all 0, out_size 4 -> 4 headers only, teof on A5030000.
REQ-039 Counts 255 each, tready toggling 1/0 every cycle -> 1024 words, order and data intact, no duplicates.
REQ-040 Second frame_ready rising edge while busy -> drop_cnt=1, first frame completes intact.
REQ-041 out_size 12 with counts summing to 6 -> size_err=1 after teof acceptance.
REQ-042 rst_n asserted during DATA -> tvalid=0 and busy=0 immediately; next frame event produces a full correct frame.
